// File: rtl/pixel_fb_sink.sv
// rtl/pixel_fb_sink.sv - pixel framebuffer with plot port and handshaked raster readback.
// Optional range checking of plot coordinates: define PIXEL_FB_BOUNDS_CHECK_EN.
module pixel_fb_sink #(
   parameter int H_RES = 160,
   parameter int V_RES = 120
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [7:0] in_x,
   input  logic [6:0] in_y,
   input  logic [2:0] in_col,
   input  logic       in_plot,
   output logic       frame_done,
   input  logic       rd_start,
   output logic       rd_valid,
   input  logic       rd_ready,
   output logic [7:0] rd_x,
   output logic [6:0] rd_y,
   output logic [2:0] rd_col,
   output logic       rd_busy,
   output logic       rd_last,
   output logic       oob_err
);

   localparam int          DEPTH   = H_RES * V_RES;
   localparam logic [7:0]  X_MAX   = 8'(H_RES - 1);
   localparam logic [6:0]  Y_MAX   = 7'(V_RES - 1);
   localparam logic [14:0] DEPTH15 = 15'(DEPTH);

   typedef enum logic [1:0] {IDLE, FETCH, PRESENT} state_t;

   logic [2:0]  mem [0:DEPTH-1];
   logic [14:0] wr_addr;
   logic [14:0] rd_addr;
   logic        addr_ok;
   logic        wr_en;
   state_t      state;

   assign wr_addr = 15'(in_y) * 15'(H_RES) + 15'(in_x);

`ifdef PIXEL_FB_BOUNDS_CHECK_EN
   logic in_range;
   assign in_range = (in_x <= X_MAX) && (in_y <= Y_MAX);
   assign addr_ok  = in_range;

   always_ff @(posedge clock) begin
      if (!reset_n)
         oob_err <= 1'b0;
      else if (in_plot && !in_range)
         oob_err <= 1'b1;
   end
`else
   // Columns past the row end alias into the next row; only addresses past the frame are dropped.
   assign addr_ok = (wr_addr < DEPTH15);
   assign oob_err = 1'b0;
`endif

   assign wr_en = reset_n && in_plot && addr_ok;

   always_ff @(posedge clock) begin
      if (wr_en)
         mem[wr_addr] <= in_col;
   end

   always_ff @(posedge clock) begin
      if (!reset_n)
         frame_done <= 1'b0;
      else
         frame_done <= in_plot && (in_x == X_MAX) && (in_y == Y_MAX);
   end

   // Read in FETCH sees the pre-edge contents, so a same-cycle write returns old data.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state    <= IDLE;
         rd_valid <= 1'b0;
         rd_busy  <= 1'b0;
         rd_last  <= 1'b0;
         rd_x     <= '0;
         rd_y     <= '0;
         rd_col   <= '0;
         rd_addr  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (rd_start) begin
                  state   <= FETCH;
                  rd_busy <= 1'b1;
                  rd_x    <= '0;
                  rd_y    <= '0;
                  rd_addr <= '0;
               end
            end
            FETCH: begin
               rd_col   <= mem[rd_addr];
               rd_valid <= 1'b1;
               rd_last  <= (rd_x == X_MAX) && (rd_y == Y_MAX);
               state    <= PRESENT;
            end
            PRESENT: begin
               if (rd_ready) begin
                  rd_valid <= 1'b0;
                  rd_last  <= 1'b0;
                  if (rd_last) begin
                     state   <= IDLE;
                     rd_busy <= 1'b0;
                  end else begin
                     state   <= FETCH;
                     rd_addr <= rd_addr + 15'd1;
                     if (rd_x == X_MAX) begin
                        rd_x <= '0;
                        rd_y <= rd_y + 7'd1;
                     end else begin
                        rd_x <= rd_x + 8'd1;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/pixel_fb_sink.md
PIXEL_FB_SINK -- requirements
Module: pixel_fb_sink

Interface
REQ-001 Parameter: H_RES, 160, pixels per row.
REQ-002 Parameter: V_RES, 120, rows per frame.
REQ-003 Port: clock  in  1  rising-edge clock.
REQ-004 Port: reset_n  in  1  reset, synchronous, active-low.
REQ-005 Port: in_x  in  8  write column.
REQ-006 Port: in_y  in  7  write row.
REQ-007 Port: in_col  in  3  write colour, RGB.
REQ-008 Port: in_plot  in  1  write strobe; one pixel per cycle while high.
REQ-009 Port: frame_done  out  1  one-cycle pulse after pixel (H_RES-1, V_RES-1) is written.
REQ-010 Port: rd_start  in  1  request a full-frame readback.
REQ-011 Port: rd_valid  out  1  readback pixel presented.
REQ-012 Port: rd_ready  in  1  consumer accepts the presented pixel.
REQ-013 Port: rd_x / rd_y / rd_col  out  8/7/3  readback coordinate and colour.
REQ-014 Port: rd_busy  out  1  readback in progress.
REQ-015 Port: rd_last  out  1  high with rd_valid on the final pixel.
REQ-016 Port: oob_err  out  1  sticky out-of-range write flag.

Function
REQ-017 Storage: H_RES*V_RES x 3-bit memory; address = in_y*H_RES + in_x, 15 bits.
REQ-018 Write: in_plot high at an edge stores in_col at that address; no backpressure.
REQ-019 frame_done: pulses the cycle after a write to (H_RES-1, V_RES-1).
REQ-020 Readback FSM states: IDLE, FETCH, PRESENT.
REQ-021 IDLE: rd_start high -> FETCH, with read address, rd_x and rd_y at 0; otherwise remain in IDLE.
REQ-022 FETCH: issue the memory read (1-cycle latency), then go to PRESENT.
REQ-023 PRESENT: rd_valid=1, and rd_x/rd_y/rd_col hold stable until rd_ready is seen.
REQ-024 PRESENT handshake: rd_valid & rd_ready on the last pixel -> IDLE; otherwise advance and go to FETCH.
REQ-025 Advance order: x increments; at x=H_RES-1, x wraps to 0 and y increments.
REQ-026 Throughput: at most one pixel per 2 cycles.
REQ-027 rd_busy: high in FETCH and PRESENT.
REQ-028 rd_start: ignored while rd_busy.
REQ-029 Write/read same cycle, same address: the read returns the old data; the write still completes.
REQ-030 Writes remain accepted during readback.
REQ-031 rd_last: high only when rd_valid and (rd_x, rd_y) = (H_RES-1, V_RES-1).

Reset
REQ-032 reset_n low at an edge: FSM goes to IDLE; rd_valid, rd_busy, rd_last, frame_done and oob_err go to 0; rd_x, rd_y and rd_col go to 0.
REQ-033 Memory contents are not cleared by reset.
REQ-034 Reset mid-readback: the sequence is abandoned, with no further rd_valid until a new rd_start.
REQ-035 A write strobed in the reset cycle is discarded.

Configuration
REQ-036 Macro PIXEL_FB_BOUNDS_CHECK_EN defined: a plot with in_x>=H_RES or in_y>=V_RES is dropped and sets oob_err; oob_err clears only on reset.
REQ-037 Macro PIXEL_FB_BOUNDS_CHECK_EN undefined: no range check and oob_err is tied 0.
REQ-038 Without the macro, addresses >=H_RES*V_RES are discarded, while in_x>=H_RES with a valid address aliases into the following row.

Verification
REQ-039 Fill test: plot all 19200 pixels with col=(x+y)%8 -> frame_done pulses once, one cycle after (159,119).
REQ-040 Readback test: rd_start with rd_ready held 1 -> 19200 beats in raster order, each col=(x+y)%8, rd_last only on (159,119), then rd_busy=0.
REQ-041 Backpressure test: hold rd_ready=0 for 5 cycles at (3,0) -> rd_x=3 and rd_col held stable, no pixel skipped or repeated.
REQ-042 Collision test: write col=5 to (0,0) (previously 2) in the same cycle the readback reads (0,0) -> beat returns 2, and a second readback returns 5.
REQ-043 Bounds test, with the macro: plot (160,0) col=7 -> oob_err=1 and (0,1) unchanged; without the macro: (0,1) reads back 7 and oob_err=0.
REQ-044 Reset test: assert reset_n=0 at beat 100 -> rd_valid=0 next cycle, rd_start is accepted afterward, and stored pixels are intact.
